// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and defaults for the E-stage multiply/divide unit
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NOP   = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_start_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational multiply/divide datapath producing {hi,lo}
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_abs_a, w_abs_b, w_den_s, w_den_u;
  logic [31:0] w_q_mag, w_r_mag, w_q_u, w_r_u;
  logic        w_b_zero;

  assign w_b_zero = (b == 32'd0);
  assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide on magnitudes; also covers 0x80000000 / -1 without overflow.
  assign w_abs_a = a[31] ? -a : a;
  assign w_abs_b = b[31] ? -b : b;
  assign w_den_s = w_b_zero ? 32'd1 : w_abs_b;
  assign w_den_u = w_b_zero ? 32'd1 : b;
  assign w_q_mag = w_abs_a / w_den_s;
  assign w_r_mag = w_abs_a % w_den_s;
  assign w_q_u   = a / w_den_u;
  assign w_r_u   = a % w_den_u;

  always_comb begin
    result = 64'd0;
    case (op)
      MDU_MULT:  result = w_prod_s;
      MDU_MULTU: result = w_prod_u;
      MDU_DIV:   result = {(a[31] ? -w_r_mag : w_r_mag),
                           ((a[31] ^ b[31]) ? -w_q_mag : w_q_mag)};
      MDU_DIVU:  result = {w_r_u, w_q_u};
      default:   result = 64'd0;
    endcase
  end

  assign div_by_zero = ((op == MDU_DIV) || (op == MDU_DIVU)) && w_b_zero;

endmodule

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage MDU: HI/LO, busy countdown FSM, mfhi/mflo mux
// Optional MDU_CANCEL_EN adds a Cancel input that aborts or suppresses operations.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic        MDUStart,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef MDU_CANCEL_EN
  input  logic        Cancel,
`endif
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam logic [3:0] LP_MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] LP_DIV_N  = 4'(DIV_CYCLES);

  mdu_state_e  r_state, w_next_state;
  logic [3:0]  r_cnt;
  logic [63:0] r_pend;
  logic        r_pend_dz;
  logic [31:0] r_hi, r_lo;
  logic [63:0] w_calc;
  logic        w_calc_dz, w_cancel, w_start, w_is_mult;

`ifdef MDU_CANCEL_EN
  assign w_cancel = Cancel;
`else
  assign w_cancel = 1'b0;
`endif

  assign w_start   = MDUStart && is_start_op(MDUOp) && !w_cancel;
  assign w_is_mult = (MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU);

  mdu_calc u_calc (
    .op          (MDUOp),
    .a           (A),
    .b           (B),
    .result      (w_calc),
    .div_by_zero (w_calc_dz)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_pend    <= 64'd0;
      r_pend_dz <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE) begin
        if (w_start) begin
          r_pend    <= w_calc;
          r_pend_dz <= w_calc_dz;
          r_cnt     <= w_is_mult ? LP_MULT_N : LP_DIV_N;
        end else if (!w_cancel) begin
          if (MDUOp == MDU_MTHI) r_hi <= A;
          if (MDUOp == MDU_MTLO) r_lo <= A;
        end
      end else if (w_cancel) begin
        r_cnt <= 4'd0;
      end else if (r_cnt == 4'd1) begin
        r_cnt <= 4'd0;
        if (!r_pend_dz) begin
          r_hi <= r_pend[63:32];
          r_lo <= r_pend[31:0];
        end
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next_state = BUSY;
      BUSY:    if (w_cancel || (r_cnt == 4'd1)) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    Busy   = (r_state == BUSY);
    HI     = r_hi;
    LO     = r_lo;
    MDUOut = 32'd0;
    if (MDUOp == MDU_MFHI) MDUOut = r_hi;
    else if (MDUOp == MDU_MFLO) MDUOut = r_lo;
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - self-checking bench for e_mdu (vector table plus scoreboard)
module tb_e_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDUOp;
  logic        MDUStart;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO, MDUOut;
`ifdef MDU_CANCEL_EN
  logic        Cancel;
`endif

  always #5 clk = ~clk;

  e_mdu dut (
    .clk      (clk),
    .reset    (reset),
    .MDUOp    (MDUOp),
    .MDUStart (MDUStart),
    .A        (A),
    .B        (B),
`ifdef MDU_CANCEL_EN
    .Cancel   (Cancel),
`endif
    .Busy     (Busy),
    .HI       (HI),
    .LO       (LO),
    .MDUOut   (MDUOut)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard empty actual=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " hi"}, HI, e.hi);
      check({tag, " lo"}, LO, e.lo);
      m_hi = e.hi;
      m_lo = e.lo;
      MDUOp = MDU_MFHI;
      #1 check({tag, " mfhi"}, MDUOut, e.hi);
      MDUOp = MDU_MFLO;
      #1 check({tag, " mflo"}, MDUOut, e.lo);
      MDUOp = MDU_NOP;
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int n,
                        input string tag);
    exp_t e;
    int   cnt;
    @(negedge clk);
    MDUOp = op; MDUStart = 1'b1; A = a; B = b;
    e.hi = ehi; e.lo = elo;
    sb.push_back(e);
    @(negedge clk);
    MDUOp = MDU_NOP; MDUStart = 1'b0; A = 32'd0; B = 32'd0;
    cnt = 0;
    while (Busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, " busy cycles"}, 32'(cnt), 32'(n));
    pop_check(tag);
  endtask

  initial begin
    logic [63:0] p;
    logic [31:0] ra, rb;
    int          cnt;

    reset = 1'b1; MDUOp = MDU_NOP; MDUStart = 1'b0; A = 32'd0; B = 32'd0;
`ifdef MDU_CANCEL_EN
    Cancel = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, Busy}, 32'd0);
    check("reset hi", HI, 32'd0);
    check("reset lo", LO, 32'd0);
    reset = 1'b0;

    vecs.push_back('{MDU_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5,  1'b0});
    vecs.push_back('{MDU_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5,  1'b0});
    vecs.push_back('{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0});
    vecs.push_back('{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, 1'b0});
    vecs.push_back('{MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10, 1'b0});
    vecs.push_back('{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10, 1'b0});
    vecs.push_back('{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5,  1'b0});
    vecs.push_back('{MDU_DIV,   32'd5,        32'd0,        32'd0,        32'd0,        10, 1'b1});
    vecs.push_back('{MDU_MULTU, 32'd0,        32'h00012345, 32'd0,        32'd0,        5,  1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].dz)
        run_op(vecs[i].op, vecs[i].a, vecs[i].b, m_hi, m_lo, vecs[i].n, $sformatf("vec%0d", i));
      else
        run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].n,
               $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      p  = {32'd0, ra} * {32'd0, rb};
      run_op(MDU_MULTU, ra, rb, p[63:32], p[31:0], 5, $sformatf("rnd%0d", i));
    end

    // MTHI, then divu by zero must leave HI untouched
    @(negedge clk);
    MDUOp = MDU_MTHI; A = 32'h12345678;
    #1 check("mthi out zero", MDUOut, 32'd0);
    @(negedge clk);
    MDUOp = MDU_MFHI; A = 32'd0;
    #1 check("mthi then mfhi", MDUOut, 32'h12345678);
    m_hi = 32'h12345678;
    run_op(MDU_DIVU, 32'd7, 32'd0, m_hi, m_lo, 10, "divu0");

    // Start/MTLO while busy are ignored; MFLO while busy returns the old LO
    @(negedge clk);
    MDUOp = MDU_MULT; MDUStart = 1'b1; A = 32'd3; B = 32'd4;
    sb.push_back('{32'd0, 32'd12});
    @(negedge clk);
    MDUOp = MDU_NOP; MDUStart = 1'b0;
    cnt = 0;
    while (Busy && cnt < 40) begin
      cnt++;
      case (cnt)
        2: begin MDUOp = MDU_MULT; MDUStart = 1'b1; A = 32'd5; B = 32'd5; end
        3: begin MDUStart = 1'b0; MDUOp = MDU_MTLO; A = 32'h0000DEAD; end
        4: begin MDUOp = MDU_MFLO; A = 32'd0; #1 check("mflo while busy", MDUOut, m_lo); end
        default: MDUOp = MDU_NOP;
      endcase
      @(negedge clk);
    end
    check("busy-ignore cycles", 32'(cnt), 32'd5);
    pop_check("busy-ignore");
    @(negedge clk);
    check("no second start", {31'd0, Busy}, 32'd0);

`ifdef MDU_CANCEL_EN
    @(negedge clk);
    MDUOp = MDU_MULT; MDUStart = 1'b1; A = 32'd6; B = 32'd7;
    @(negedge clk);
    MDUOp = MDU_NOP; MDUStart = 1'b0;
    repeat (2) @(negedge clk);
    Cancel = 1'b1;
    @(negedge clk);
    Cancel = 1'b0;
    check("cancel busy drop", {31'd0, Busy}, 32'd0);
    check("cancel hi kept", HI, m_hi);
    check("cancel lo kept", LO, m_lo);
    MDUOp = MDU_MULT; MDUStart = 1'b1; Cancel = 1'b1;
    @(negedge clk);
    check("cancel suppress start", {31'd0, Busy}, 32'd0);
    MDUStart = 1'b0; MDUOp = MDU_MTHI; A = 32'hCAFEF00D;
    @(negedge clk);
    Cancel = 1'b0; MDUOp = MDU_NOP;
    repeat (12) @(negedge clk);
    check("cancel suppress mthi", HI, m_hi);
    check("cancel lo final", LO, m_lo);
`endif

    // Async reset in the middle of a divide discards it
    @(negedge clk);
    MDUOp = MDU_DIVU; MDUStart = 1'b1; A = 32'd100; B = 32'd7;
    @(negedge clk);
    MDUOp = MDU_MULT; A = 32'd9; B = 32'd9;
    @(negedge clk);
    MDUOp = MDU_NOP; MDUStart = 1'b0;
    repeat (2) @(negedge clk);
    check("pre-reset busy", {31'd0, Busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async reset busy", {31'd0, Busy}, 32'd0);
    check("async reset hi", HI, 32'd0);
    check("async reset lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("post-reset busy", {31'd0, Busy}, 32'd0);
    check("post-reset hi", HI, 32'd0);
    check("post-reset lo", LO, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit, directly downstream of the decode control unit.
- Consumes the decoded MDUOp/MDUStart with the E-stage operands, and holds the architectural HI/LO registers.
- Exposes Busy so the hazard unit can stall MDU instructions in D while an operation is pending.
- Returns HI/LO to the E-stage write-back mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, number of cycles Busy stays high for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, number of cycles Busy stays high for div/divu (legal range 1..15).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- MDUOp  input  4  operation code: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8; codes 9..15 behave as NOP.
- MDUStart  input  1  high for exactly the E cycle of mult/multu/div/divu.
- A  input  32  forwarded rs operand.
- B  input  32  forwarded rt operand.
- Busy  output  1  high while a mult/div result is pending.
- HI  output  32  current HI register.
- LO  output  32  current LO register.
- MDUOut  output  32  HI when MDUOp=MFHI, LO when MDUOp=MFLO, otherwise 0; combinational.

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, HI=0, LO=0, counter=0, pending result=0, Busy=0; any in-flight operation is discarded.
- States:
  - IDLE: Busy=0.
  - BUSY: Busy=1, counter counts down to 1.
- IDLE -> BUSY on an edge where MDUStart=1 and MDUOp is MULT/MULTU/DIV/DIVU.
  - At that edge: compute and latch the 64-bit pending result from A, B.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
- BUSY, counter>1: decrement.
- BUSY, counter==1: at that edge commit pending {hi,lo} to HI/LO, state -> IDLE.
- Result: Busy is high for exactly N cycles, starting the cycle after the start edge. HI/LO show the new value from cycle N+1 after start.
- MDUStart with a non-start MDUOp: ignored.
- mult: {HI,LO} = signed 64-bit product.
- multu: {HI,LO} = unsigned 64-bit product.
- div: LO = signed quotient truncated toward zero; HI = remainder, taking the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: LO = unsigned quotient, HI = unsigned remainder.
- Divide by zero (B==0, div or divu): the full latency still elapses, then HI/LO are left unchanged.
- MTHI/MTLO in IDLE: HI (resp. LO) := A at the edge; visible on MDUOut the next cycle.
- MTHI/MTLO while BUSY: ignored (the hazard unit guarantees this does not occur).
- MDUStart while BUSY: ignored; the in-flight operation continues.
- MFHI/MFLO while BUSY: return the pre-operation HI/LO (stalling is the hazard unit's job).
- MFHI/MFLO in the same cycle as MTHI/MTLO: return the old value (no internal bypass).

Optional Feature:
- Macro: MDU_CANCEL_EN.
- Defined:
  - Adds input port Cancel (1 bit).
  - Cancel=1 at an edge while BUSY: state -> IDLE, Busy=0 next cycle, HI/LO keep their pre-operation values.
  - Cancel=1 with MDUStart=1 in IDLE: the start is suppressed.
  - Cancel has priority over the counter==1 commit.
  - Cancel also suppresses MTHI/MTLO in the same cycle.
  - Exists for future exception/flush support.
- Undefined: the port is absent and every started operation always commits.

Decomposition:
- Package mdu_pkg:
  - MDUOp encodings (MDU_NOP..MDU_MTLO).
  - Default MULT_CYCLES/DIV_CYCLES constants.
  - State encodings IDLE/BUSY.
- One combinational sub-module, mdu_calc:
  - Inputs: op, A, B.
  - Outputs: 64-bit {hi,lo} and a div_by_zero flag.
  - Contains signed/unsigned multiply and divide, including remainder sign fix-up.
- e_mdu holds the FSM, counter, pending result, HI/LO and the output mux.

Test Plan:
- Reset, then MULT with A=0xFFFFFFFF, B=2: Busy high cycles 1..5 exactly; from cycle 6 HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU with A=0xFFFFFFFF, B=2: HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- DIV with A=0xFFFFFFF9 (-7), B=2: Busy high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI A=0x12345678, then DIVU A=7, B=0: after 10 busy cycles HI=0x12345678 is unchanged; MFHI gives MDUOut=0x12345678.
- DIVU started, reset asserted at busy cycle 4: Busy=0 and HI=LO=0 immediately (async). A MULT issued while BUSY is ignored: only the first result commits.
- With MDU_CANCEL_EN, Cancel at busy cycle 3 of MULT: HI/LO keep their old values and Busy drops the next cycle.
